// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared definitions for the instruction-memory boot loader.
//   - 3-bit state encoding (localparams plus the matching enum type)
//   - SRAM byte-enable constants
package imem_loader_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RECV  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_READ  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;
  localparam logic [2:0] ST_CMP   = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_RECV  = ST_RECV,
    S_WRITE = ST_WRITE,
    S_READ  = ST_READ,
    S_DRAIN = ST_DRAIN,
    S_CMP   = ST_CMP,
    S_DONE  = ST_DONE
  } state_t;

  localparam logic [3:0] BE_ALL  = 4'b1111;
  localparam logic [3:0] BE_NONE = 4'b0000;

endpackage

// File: rtl/imem_loader_word_pack.sv
// loader_word_pack: assembles a byte stream into little-endian 32-bit words.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   clear        discard any partial word and restart at lane 0
//   in_valid     a byte is accepted this cycle
//   in_data      the accepted byte
//   word_next    current partial word with in_data inserted at the active lane
//   word_full    the accepted byte completes a word (word_next is the full word)
module loader_word_pack (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic [31:0] word_next,
  output logic        word_full
);

  logic [1:0]  byte_idx;
  logic [31:0] word_q;

  always_comb begin
    word_next = word_q;
    case (byte_idx)
      2'd0: word_next[7:0]   = in_data;
      2'd1: word_next[15:8]  = in_data;
      2'd2: word_next[23:16] = in_data;
      default: word_next[31:24] = in_data;
    endcase
  end

  assign word_full = in_valid && (byte_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      byte_idx <= 2'd0;
      word_q   <= '0;
    end else if (in_valid) begin
      byte_idx <= byte_idx + 2'd1;
      word_q   <= word_next;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the instruction SRAM. Receives a byte
// stream, writes little-endian words, reads them back, verifies an additive
// checksum and releases the core reset only on a verified image.
// Ports:
//   CLK, RSTn            clock, synchronous active-low reset
//   START                one-cycle load request (honoured in IDLE/DONE only)
//   WORD_CNT, CHECKSUM   load size and expected sum, sampled on START
//   S_VALID/S_DATA/S_READY  byte stream handshake
//   MEM_*                single-port SRAM interface (read data 1 cycle late)
//   BUSY, DONE, ERR      status; DONE and ERR sticky until next START
//   CORE_RSTn            core reset, released when DONE=1 and ERR=0
//
// state   | meaning
// IDLE    | waiting for START after reset
// RECV    | accepting stream bytes for the current word
// WRITE   | one-cycle SRAM write of the assembled word
// READ    | one read per cycle over the loaded range
// DRAIN   | absorb the final read word into the accumulator
// CMP     | compare accumulator with the expected checksum
// DONE    | load finished; status held until next START
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int AWIDTH = 10,
  parameter int SIZE   = 1024
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              START,
  input  logic [AWIDTH:0]   WORD_CNT,
  input  logic [31:0]       CHECKSUM,
  input  logic              S_VALID,
  input  logic [7:0]        S_DATA,
  output logic              S_READY,
  output logic              MEM_CSN,
  output logic              MEM_WEN,
  output logic [3:0]        MEM_BE,
  output logic [31:0]       MEM_ADDR,
  output logic [31:0]       MEM_DI,
  input  logic [31:0]       MEM_DOUT,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic              CORE_RSTn
);

  localparam logic [AWIDTH:0] SIZE_W = (AWIDTH+1)'(SIZE);

  function automatic logic [31:0] word_addr(input logic [AWIDTH-1:0] idx);
    logic [31:0] a;
    a = '0;
    a[AWIDTH+1:2] = idx;
    return a;
  endfunction

  state_t            state;
  logic [AWIDTH:0]   cnt;
  logic [31:0]       chk;
  logic [AWIDTH-1:0] word_idx;
  logic [31:0]       acc;
  logic              rd_valid;

  logic              start_go;
  logic              byte_acc;
  logic [31:0]       word_next;
  logic              word_full;
  logic [AWIDTH:0]   cnt_m1;
  logic              last_word;

  assign start_go  = START && (state == S_IDLE || state == S_DONE);
  // S_READY is only ever high while in RECV, so this is the whole accept term.
  assign byte_acc  = S_VALID && S_READY;
  assign cnt_m1    = cnt - 1'b1;
  assign last_word = ({1'b0, word_idx} == cnt_m1);

  loader_word_pack u_pack (
    .clk       (CLK),
    .rst_n     (RSTn),
    .clear     (start_go),
    .in_valid  (byte_acc),
    .in_data   (S_DATA),
    .word_next (word_next),
    .word_full (word_full)
  );

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state     <= S_IDLE;
      cnt       <= '0;
      chk       <= '0;
      word_idx  <= '0;
      acc       <= '0;
      rd_valid  <= 1'b0;
      S_READY   <= 1'b0;
      MEM_CSN   <= 1'b1;
      MEM_WEN   <= 1'b1;
      MEM_BE    <= BE_NONE;
      MEM_ADDR  <= '0;
      MEM_DI    <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      CORE_RSTn <= 1'b0;
    end else begin
      // Read data returns one cycle after the access, so accumulate one cycle late.
      rd_valid <= (state == S_READ);
      if (rd_valid) acc <= acc + MEM_DOUT;

      case (state)
        S_IDLE, S_DONE: begin
          if (state == S_DONE) CORE_RSTn <= ~ERR;
          if (START) begin
            cnt       <= WORD_CNT;
            chk       <= CHECKSUM;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
            word_idx  <= '0;
            acc       <= '0;
            CORE_RSTn <= 1'b0;
            if (WORD_CNT > SIZE_W) begin
              ERR   <= 1'b1;
              DONE  <= 1'b1;
              state <= S_DONE;
            end else if (WORD_CNT == '0) begin
              BUSY  <= 1'b1;
              state <= S_CMP;
            end else begin
              BUSY    <= 1'b1;
              S_READY <= 1'b1;
              state   <= S_RECV;
            end
          end
        end

        S_RECV: begin
          if (word_full) begin
            S_READY  <= 1'b0;
            MEM_CSN  <= 1'b0;
            MEM_WEN  <= 1'b0;
            MEM_BE   <= BE_ALL;
            MEM_ADDR <= word_addr(word_idx);
            MEM_DI   <= word_next;
            state    <= S_WRITE;
          end
        end

        S_WRITE: begin
          MEM_BE  <= BE_NONE;
          MEM_WEN <= 1'b1;
          if (last_word) begin
            word_idx <= '0;
            MEM_CSN  <= 1'b0;
            MEM_ADDR <= '0;
            state    <= S_READ;
          end else begin
            word_idx <= word_idx + 1'b1;
            MEM_CSN  <= 1'b1;
            S_READY  <= 1'b1;
            state    <= S_RECV;
          end
        end

        S_READ: begin
          if (last_word) begin
            MEM_CSN <= 1'b1;
            state   <= S_DRAIN;
          end else begin
            word_idx <= word_idx + 1'b1;
            MEM_ADDR <= word_addr(word_idx + 1'b1);
          end
        end

        S_DRAIN: state <= S_CMP;

        S_CMP: begin
          ERR   <= (acc != chk);
          DONE  <= 1'b1;
          BUSY  <= 1'b0;
          state <= S_DONE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader with a
// behavioural SRAM and an access logger.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [10:0] word_cnt;
  logic [31:0] checksum;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        mem_csn, mem_wen;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_di;
  logic [31:0] mem_dout = '0;
  logic        busy, done, err, core_rstn;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc, done_cyc;

  logic [31:0] mem [0:1023];
  int          n_acc;
  logic        log_we   [64];
  logic [31:0] log_addr [64];
  logic [31:0] log_data [64];
  logic [3:0]  log_be   [64];
  bit          csn_seen, rdy_seen;

  imem_loader dut (
    .CLK(clk), .RSTn(rst_n), .START(start), .WORD_CNT(word_cnt), .CHECKSUM(checksum),
    .S_VALID(s_valid), .S_DATA(s_data), .S_READY(s_ready),
    .MEM_CSN(mem_csn), .MEM_WEN(mem_wen), .MEM_BE(mem_be), .MEM_ADDR(mem_addr),
    .MEM_DI(mem_di), .MEM_DOUT(mem_dout),
    .BUSY(busy), .DONE(done), .ERR(err), .CORE_RSTn(core_rstn)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!mem_csn) begin
      if (mem_wen) mem_dout <= mem[mem_addr[11:2]];
      else         mem[mem_addr[11:2]] <= mem_di;
    end
  end

  always @(negedge clk) begin
    if (!mem_csn) begin
      csn_seen = 1'b1;
      if (n_acc < 64) begin
        log_we[n_acc]   = !mem_wen;
        log_addr[n_acc] = mem_addr;
        log_data[n_acc] = mem_di;
        log_be[n_acc]   = mem_be;
      end
      n_acc++;
    end
    if (s_ready) rdy_seen = 1'b1;
  end

  task automatic clear_log();
    n_acc = 0;
    csn_seen = 1'b0;
    rdy_seen = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [10:0] cnt, input logic [31:0] sum);
    start = 1'b1;
    word_cnt = cnt;
    checksum = sum;
    tick();
    start = 1'b0;
    start_cyc = cyc;
  endtask

  // Sends n bytes from v (byte 0 first); gap idle cycles after each byte.
  task automatic send_bytes(input logic [63:0] v, input int n, input int gap, output bit to);
    int k;
    to = 1'b0;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = v[8*i +: 8];
      k = 0;
      while (!s_ready && k < 50) begin
        tick();
        k++;
      end
      if (k == 50) to = 1'b1;
      tick();
      s_valid = 1'b0;
      repeat (gap) tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit to);
    int k;
    k = 0;
    while (!done && k < bound) begin
      tick();
      k++;
    end
    to = !done;
    done_cyc = cyc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    if ({s_ready, mem_csn, mem_wen, mem_be} !== 7'b0110000) begin
      $display("FAIL reset_mem_ctl: got rdy/csn/wen/be=%b expected 0110000", {s_ready, mem_csn, mem_wen, mem_be});
      errors++;
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_di !== 32'h0) begin
      $display("FAIL reset_addr_di: got addr=%h di=%h expected 0/0", mem_addr, mem_di);
      errors++;
    end
    checks++;
    if ({busy, done, err, core_rstn} !== 4'b0000) begin
      $display("FAIL reset_status: got busy/done/err/core_rstn=%b expected 0000", {busy, done, err, core_rstn});
      errors++;
    end
    checks++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_normal_load();
    bit to1, to2;
    clear_log();
    pulse_start(11'd2, 32'h001000A6);
    send_bytes(64'h0010009300000013, 8, 0, to1);
    wait_done(100, to2);
    if (to1 || to2) begin
      $display("FAIL normal_timeout: stream_to=%0d done_to=%0d expected 0/0", to1, to2);
      errors++;
    end
    checks++;
    if (n_acc !== 4) begin
      $display("FAIL normal_acc_count: got %0d expected 4", n_acc);
      errors++;
    end
    checks++;
    if (log_we[0] !== 1'b1 || log_addr[0] !== 32'h0 || log_data[0] !== 32'h00000013 || log_be[0] !== 4'hF) begin
      $display("FAIL normal_wr0: got we=%b addr=%h data=%h be=%h expected 1/0/00000013/f", log_we[0], log_addr[0], log_data[0], log_be[0]);
      errors++;
    end
    checks++;
    if (log_we[1] !== 1'b1 || log_addr[1] !== 32'h4 || log_data[1] !== 32'h00100093 || log_be[1] !== 4'hF) begin
      $display("FAIL normal_wr1: got we=%b addr=%h data=%h be=%h expected 1/4/00100093/f", log_we[1], log_addr[1], log_data[1], log_be[1]);
      errors++;
    end
    checks++;
    if (log_we[2] !== 1'b0 || log_addr[2] !== 32'h0 || log_be[2] !== 4'h0 ||
        log_we[3] !== 1'b0 || log_addr[3] !== 32'h4 || log_be[3] !== 4'h0) begin
      $display("FAIL normal_reads: got we=%b/%b addr=%h/%h be=%h/%h expected 0/0 0/4 0/0",
               log_we[2], log_we[3], log_addr[2], log_addr[3], log_be[2], log_be[3]);
      errors++;
    end
    checks++;
    // 6N+3 counts the START cycle itself.
    if (done_cyc - start_cyc + 1 !== 15) begin
      $display("FAIL normal_latency: got %0d cycles expected 15", done_cyc - start_cyc + 1);
      errors++;
    end
    checks++;
    if ({busy, err, core_rstn} !== 3'b000) begin
      $display("FAIL normal_done_entry: got busy/err/core_rstn=%b expected 000", {busy, err, core_rstn});
      errors++;
    end
    checks++;
    tick();
    if ({done, err, core_rstn} !== 3'b101) begin
      $display("FAIL normal_release: got done/err/core_rstn=%b expected 101", {done, err, core_rstn});
      errors++;
    end
    checks++;
  endtask

  task automatic test_bad_checksum();
    bit to1, to2;
    clear_log();
    pulse_start(11'd2, 32'h001000A7);
    if (core_rstn !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL bad_restart: got core_rstn/done/busy=%b%b%b expected 001", core_rstn, done, busy);
      errors++;
    end
    checks++;
    send_bytes(64'h0010009300000013, 8, 0, to1);
    wait_done(100, to2);
    repeat (2) tick();
    if (to1 || to2 || {done, err, core_rstn} !== 3'b110) begin
      $display("FAIL bad_checksum: got done/err/core_rstn=%b timeouts=%0d%0d expected 110 00", {done, err, core_rstn}, to1, to2);
      errors++;
    end
    checks++;
  endtask

  task automatic test_backpressure();
    bit to1, to2;
    clear_log();
    pulse_start(11'd2, 32'h001000A6);
    send_bytes(64'h0010009300000013, 8, 3, to1);
    wait_done(200, to2);
    tick();
    if (to1 || to2 || n_acc !== 4) begin
      $display("FAIL bp_acc_count: got %0d timeouts=%0d%0d expected 4 00", n_acc, to1, to2);
      errors++;
    end
    checks++;
    if (log_data[0] !== 32'h00000013 || log_data[1] !== 32'h00100093 ||
        log_addr[1] !== 32'h4 || log_we[2] !== 1'b0 || log_addr[3] !== 32'h4) begin
      $display("FAIL bp_accesses: got d0=%h d1=%h a1=%h we2=%b a3=%h expected 00000013 00100093 4 0 4",
               log_data[0], log_data[1], log_addr[1], log_we[2], log_addr[3]);
      errors++;
    end
    checks++;
    if ({done, err, core_rstn} !== 3'b101) begin
      $display("FAIL bp_status: got done/err/core_rstn=%b expected 101", {done, err, core_rstn});
      errors++;
    end
    checks++;
  endtask

  task automatic test_zero_length();
    bit to;
    clear_log();
    pulse_start(11'd0, 32'h0);
    wait_done(10, to);
    if (to || done_cyc - start_cyc > 2) begin
      $display("FAIL zero_latency: got %0d cycles after START timeout=%0d expected <=2 0", done_cyc - start_cyc, to);
      errors++;
    end
    checks++;
    repeat (2) tick();
    if (csn_seen || {done, err, core_rstn} !== 3'b101) begin
      $display("FAIL zero_status: got csn_seen=%0d done/err/core_rstn=%b expected 0 101", csn_seen, {done, err, core_rstn});
      errors++;
    end
    checks++;
  endtask

  task automatic test_oversize();
    clear_log();
    pulse_start(11'd1025, 32'h0);
    s_valid = 1'b1;
    s_data  = 8'h55;
    repeat (5) tick();
    s_valid = 1'b0;
    if ({done, err, core_rstn, busy} !== 4'b1100) begin
      $display("FAIL oversize_status: got done/err/core_rstn/busy=%b expected 1100", {done, err, core_rstn, busy});
      errors++;
    end
    checks++;
    if (csn_seen || rdy_seen) begin
      $display("FAIL oversize_quiet: got csn_seen=%0d rdy_seen=%0d expected 0 0", csn_seen, rdy_seen);
      errors++;
    end
    checks++;
  endtask

  task automatic test_reset_mid_load();
    bit to1, to2;
    pulse_start(11'd1, 32'h11111111);
    send_bytes(64'h0000000000002211, 2, 0, to1);
    clear_log();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    if ({s_ready, mem_csn, mem_wen, mem_be, busy, done, err, core_rstn} !== 11'b01100000000 ||
        mem_addr !== 32'h0 || mem_di !== 32'h0) begin
      $display("FAIL midrst_outputs: got rdy/csn/wen/be/busy/done/err/crst=%b addr=%h di=%h expected 01100000000 0 0",
               {s_ready, mem_csn, mem_wen, mem_be, busy, done, err, core_rstn}, mem_addr, mem_di);
      errors++;
    end
    checks++;
    tick();
    if (n_acc !== 0 || to1) begin
      $display("FAIL midrst_no_access: got %0d accesses stream_to=%0d expected 0 0", n_acc, to1);
      errors++;
    end
    checks++;
    pulse_start(11'd1, 32'hDDCCBBAA);
    send_bytes(64'h00000000DDCCBBAA, 4, 0, to1);
    wait_done(100, to2);
    tick();
    if (to1 || to2 || n_acc !== 2 || log_we[0] !== 1'b1 || log_addr[0] !== 32'h0 || log_data[0] !== 32'hDDCCBBAA) begin
      $display("FAIL midrst_reload_wr: got n=%0d we=%b addr=%h data=%h timeouts=%0d%0d expected 2 1 0 ddccbbaa 00",
               n_acc, log_we[0], log_addr[0], log_data[0], to1, to2);
      errors++;
    end
    checks++;
    if ({done, err, core_rstn} !== 3'b101) begin
      $display("FAIL midrst_reload_status: got done/err/core_rstn=%b expected 101", {done, err, core_rstn});
      errors++;
    end
    checks++;
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    word_cnt = '0;
    checksum = '0;
    s_valid  = 1'b0;
    s_data   = '0;
    clear_log();
    test_reset();
    test_normal_load();
    test_bad_checksum();
    test_backpressure();
    test_zero_length();
    test_oversize();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
